// File: rtl/clcd_ctrl.sv
// clcd_ctrl: character-LCD write sequencer. Runs the HD44780 power-on init
// sequence after reset, then drains a host FIFO of {RS, DQ} bytes. Each byte
// becomes a timed RS/RW/E/DQ write cycle followed by an execution wait.
module clcd_ctrl #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned T_AS    = 2,
    parameter int unsigned T_EH    = 12,
    parameter int unsigned T_AH    = 2,
    parameter int unsigned T_EXEC  = 2500,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned T_PWR   = 750000
) (
    input  logic               clk,
    input  logic               nRESET,
    input  logic               i_wr_en,
    input  logic [8:0]         i_wr_data,
    input  logic               i_ovf_clr,
    output logic [FIFO_AW:0]   o_fifo_level,
    output logic               o_fifo_full,
    output logic               o_overflow,
    output logic               o_init_done,
    output logic               o_busy,
    output logic               o_clcd_rs,
    output logic               o_clcd_rw,
    output logic               o_clcd_e,
    output logic [7:0]         o_clcd_dq
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned LVL_W   = FIFO_AW + 1;
    localparam int unsigned CNT_MAX = max2(max2(max2(T_AS, T_EH), max2(T_AH, T_EXEC)),
                                           max2(T_CLR, T_PWR));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] AS_LAST   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] EH_LAST   = CNT_W'(T_EH - 1);
    localparam logic [CNT_W-1:0] AH_LAST   = CNT_W'(T_AH - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        StPwrWait,
        StInitLoad,
        StIdle,
        StSetup,
        StEHigh,
        StHold,
        StExecWait
    } state_e;

    // HD44780 8-bit power-on sequence: function set x3, display on, clear, entry mode
    function automatic logic [8:0] init_rom(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 9'h038;
            3'd3:             return 9'h00C;
            3'd4:             return 9'h001;
            default:          return 9'h006;
        endcase
    endfunction

    state_e             r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [2:0]         r_init_k, w_init_k_d;
    logic               r_init_done, w_init_done_d;
    logic               r_rs, w_rs_d;
    logic [7:0]         r_dq, w_dq_d;
    logic               r_e, w_e_d;

    logic [8:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]   r_level, w_level_d;
    logic               r_full;
    logic               r_ovf, w_ovf_d;
    logic               r_busy, w_busy_d;

    logic               w_push;
    logic               w_pop;
    logic               w_is_clr;
    logic [CNT_W-1:0]   w_exec_last;

    // Clear/home commands need the long execution wait
    assign w_is_clr    = !r_rs && (r_dq[7:2] == 6'd0) && (r_dq[1:0] != 2'd0);
    assign w_exec_last = w_is_clr ? CLR_LAST : EXEC_LAST;

    // A push into a full FIFO is still accepted when the head leaves on the same edge
    assign w_push    = i_wr_en && (!r_full || w_pop);
    assign w_level_d = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_e_d     = (w_state_d == StEHigh);
    assign w_busy_d  = !w_init_done_d || (w_state_d != StIdle) || (w_level_d != '0);

    // Overflow is sticky; a coincident overflowing push beats the clear
    always_comb begin
        w_ovf_d = r_ovf;
        if (i_ovf_clr) begin
            w_ovf_d = 1'b0;
        end
        if (i_wr_en && !w_push) begin
            w_ovf_d = 1'b1;
        end
    end

    // Sequencer next-state: phase timing, init ROM walk and FIFO pop
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_init_k_d    = r_init_k;
        w_init_done_d = r_init_done;
        w_rs_d        = r_rs;
        w_dq_d        = r_dq;
        w_pop         = 1'b0;
        case (r_state)
            StPwrWait: begin
                if (r_cnt == PWR_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StInitLoad;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StInitLoad: begin
                {w_rs_d, w_dq_d} = init_rom(r_init_k);
                w_cnt_d          = '0;
                w_state_d        = StSetup;
            end
            StIdle: begin
                if (r_init_done && (r_level != '0)) begin
                    w_pop            = 1'b1;
                    {w_rs_d, w_dq_d} = r_mem[r_rd_ptr];
                    w_cnt_d          = '0;
                    w_state_d        = StSetup;
                end
            end
            StSetup: begin
                if (r_cnt == AS_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StEHigh;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StEHigh: begin
                if (r_cnt == EH_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StHold;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StHold: begin
                if (r_cnt == AH_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StExecWait;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StExecWait: begin
                if (r_cnt == w_exec_last) begin
                    w_cnt_d = '0;
                    if (r_init_done) begin
                        w_state_d = StIdle;
                    end else if (r_init_k == 3'd5) begin
                        w_init_done_d = 1'b1;
                        w_init_k_d    = 3'd0;
                        w_state_d     = StIdle;
                    end else begin
                        w_init_k_d = r_init_k + 3'd1;
                        w_state_d  = StInitLoad;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = StPwrWait;
            end
        endcase
    end

    // Sequencer, bus and status registers; reset drops E immediately
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= StPwrWait;
            r_cnt       <= '0;
            r_init_k    <= 3'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_dq        <= 8'h00;
            r_e         <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_init_k    <= w_init_k_d;
            r_init_done <= w_init_done_d;
            r_rs        <= w_rs_d;
            r_dq        <= w_dq_d;
            r_e         <= w_e_d;
            r_level     <= w_level_d;
            r_full      <= (w_level_d == LVL_FULL);
            r_ovf       <= w_ovf_d;
            r_busy      <= w_busy_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_fifo_level = r_level;
    assign o_fifo_full  = r_full;
    assign o_overflow   = r_ovf;
    assign o_init_done  = r_init_done;
    assign o_busy       = r_busy;
    assign o_clcd_rs    = r_rs;
    assign o_clcd_rw    = 1'b0;
    assign o_clcd_e     = r_e;
    assign o_clcd_dq    = r_dq;

endmodule

// File: tb/tb_clcd_ctrl.sv
// Bench for clcd_ctrl: directed phases with random data and random traffic,
// every output compared each cycle against a timeline model of pop edges.
module tb_clcd_ctrl;

    localparam int unsigned FIFO_AW = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned T_AS    = 2;
    localparam int unsigned T_EH    = 4;
    localparam int unsigned T_AH    = 2;
    localparam int unsigned T_EXEC  = 20;
    localparam int unsigned T_CLR   = 50;
    localparam int unsigned T_PWR   = 100;

    logic       clk     = 1'b0;
    logic       nRESET  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [8:0] wr_data = 9'h000;
    logic       ovf_clr = 1'b0;
    logic [2:0] fifo_level;
    logic       fifo_full, overflow, init_done, busy;
    logic       clcd_rs, clcd_rw, clcd_e;
    logic [7:0] clcd_dq;

    clcd_ctrl #(
        .FIFO_AW (FIFO_AW),
        .T_AS    (T_AS),
        .T_EH    (T_EH),
        .T_AH    (T_AH),
        .T_EXEC  (T_EXEC),
        .T_CLR   (T_CLR),
        .T_PWR   (T_PWR)
    ) u_dut (
        .clk          (clk),
        .nRESET       (nRESET),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .i_ovf_clr    (ovf_clr),
        .o_fifo_level (fifo_level),
        .o_fifo_full  (fifo_full),
        .o_overflow   (overflow),
        .o_init_done  (init_done),
        .o_busy       (busy),
        .o_clcd_rs    (clcd_rs),
        .o_clcd_rw    (clcd_rw),
        .o_clcd_e     (clcd_e),
        .o_clcd_dq    (clcd_dq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: edges since reset, earliest edge of the next pop, queued words
    logic [8:0] rom [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    int         m_n, m_f, m_init_idx, m_done_edge, m_last_p;
    logic [8:0] m_q [$];
    logic [8:0] m_word;
    logic       m_ovf;

    function automatic int period(input logic [8:0] w);
        bit clr = (w[8] == 1'b0) && (w[7:2] == 6'd0) && (w[1:0] != 2'd0);
        return 1 + T_AS + T_EH + T_AH + (clr ? T_CLR : T_EXEC);
    endfunction

    function automatic bit m_done();
        return (m_init_idx == 6) && (m_n >= m_done_edge);
    endfunction

    function automatic bit m_e();
        return (m_n >= m_last_p + T_AS) && (m_n < m_last_p + T_AS + T_EH);
    endfunction

    function automatic bit m_busy();
        return !m_done() || (m_n < m_f - 1) || (m_q.size() != 0);
    endfunction

    function automatic bit pop_next();
        return (m_init_idx == 6) && (m_n + 1 >= m_f) && (m_q.size() > 0);
    endfunction

    function automatic logic [8:0] rand_word();
        return {1'($urandom), 8'($urandom)};
    endfunction

    task automatic model_reset();
        m_n         = 0;
        m_f         = T_PWR + 1;
        m_init_idx  = 0;
        m_done_edge = 0;
        m_last_p    = -1000;
        m_q.delete();
        m_word      = 9'h000;
        m_ovf       = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [8:0] wd, input logic oc);
        bit ovf_set = 1'b0;
        m_n++;
        if (m_init_idx < 6) begin
            if (m_n == m_f) begin
                m_word   = rom[m_init_idx];
                m_last_p = m_n;
                m_f      = m_n + period(m_word);
                m_init_idx++;
                if (m_init_idx == 6) m_done_edge = m_f - 1;
            end
        end else if ((m_n >= m_f) && (m_q.size() > 0)) begin
            m_word   = m_q.pop_front();
            m_last_p = m_n;
            m_f      = m_n + period(m_word);
        end
        if (we) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else ovf_set = 1'b1;
        end
        if (oc) m_ovf = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, m_n, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level", 32'(fifo_level), m_q.size());
        chk("full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("init_done", 32'(init_done), 32'(m_done()));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("e", 32'(clcd_e), 32'(m_e()));
        chk("rs", 32'(clcd_rs), 32'(m_word[8]));
        chk("dq", 32'(clcd_dq), 32'(m_word[7:0]));
        chk("rw", 32'(clcd_rw), 32'd0);
    endtask

    // Called at a negedge: drive inputs, advance one edge, check at the next negedge
    task automatic step(input logic we, input logic [8:0] wd, input logic oc);
        wr_en   = we;
        wr_data = wd;
        ovf_clr = oc;
        @(posedge clk);
        model_edge(we, wd, oc);
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check_outputs();
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget && m_busy(); i++) step(1'b0, 9'h000, 1'b0);
        chk("reached_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_e_high(input string tag);
        for (int i = 0; i < 100 && !m_e(); i++) step(1'b0, 9'h000, 1'b0);
        chk(tag, 32'(clcd_e), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_e"}, 32'(clcd_e), 32'd0);
        chk({tag, "_rs"}, 32'(clcd_rs), 32'd0);
        chk({tag, "_rw"}, 32'(clcd_rw), 32'd0);
        chk({tag, "_dq"}, 32'(clcd_dq), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_full"}, 32'(fifo_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        nRESET = 1'b1;
        model_reset();

        // Three pushes during the power-up wait, held until init completes
        for (int i = 0; i < 9; i++) step(1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0);
        run_until_idle(800);

        // Single data byte 'A'
        step(1'b1, 9'h141, 1'b0);
        run_until_idle(200);

        // Burst of six while E is high: two overflow, the last with a clear (set wins)
        step(1'b1, rand_word(), 1'b0);
        wait_e_high("e_high_before_burst");
        for (int i = 0; i < 6; i++) step(1'b1, rand_word(), 1'(i == 5));
        chk("burst_overflow", 32'(overflow), 32'd1);
        step(1'b0, 9'h000, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        run_until_idle(800);

        // Keep the FIFO full and push on each pop edge to walk the pointers round
        for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 200 && !pop_next(); i++) step(1'b0, 9'h000, 1'b0);
            chk("full_before_swap", 32'(fifo_level), 32'd4);
            step(1'b1, rand_word(), 1'b0);
        end
        run_until_idle(1000);

        // Random traffic with occasional overflow clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 5) == 0), rand_word(), 1'($urandom_range(0, 15) == 0));
        end
        run_until_idle(1500);

        // Asynchronous reset in the middle of an E pulse
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0);
        wait_e_high("e_before_reset");
        #2 nRESET = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        nRESET = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) step(1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 160; i++) step(1'b0, 9'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
